// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: opcodes, FSM states
// and register-file geometry defaults.
package alu_seq_pkg;

    localparam int NREGS_DEF = 8;
    localparam int AW_DEF    = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } seq_state_e;

    function automatic logic is_illegal(input logic [2:0] op);
        logic ill;
        case (op)
            3'b110:  ill = 1'b1;
            3'b111:  ill = 1'b1;
            default: ill = 1'b0;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the sequencer: two operand read ports, one debug read
// port, per-entry write where writeback beats the direct load; r0 reads 0.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rs1_addr,
    output logic [15:0]   rs1_data,
    input  logic [AW-1:0] rs2_addr,
    output logic [15:0]   rs2_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [15:0]   dbg_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [15:0]   wb_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [15:0]   ld_data
);

    logic [15:0] mem_r [NREGS];

    function automatic logic [15:0] rf_read(input logic [AW-1:0] a);
        logic [15:0] d;
        if (a == '0) begin
            d = 16'h0000;
        end else begin
            d = mem_r[a];
        end
        return d;
    endfunction

    // Storage update; a load and a writeback to different entries both land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= 16'h0000;
            end
        end else begin
            mem_r[0] <= 16'h0000;
            for (int i = 1; i < NREGS; i++) begin
                if (wb_en && (wb_addr == AW'(i))) begin
                    mem_r[i] <= wb_data;
                end else if (ld_en && (ld_addr == AW'(i))) begin
                    mem_r[i] <= ld_data;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    // Combinational read ports.
    always_comb begin
        rs1_data = rf_read(rs1_addr);
        rs2_data = rf_read(rs2_addr);
        dbg_data = rf_read(dbg_addr);
    end

endmodule

// File: rtl/structural_alu.sv
// Team 16-bit ALU with its own operand/opcode latches; the result is a
// combinational function of the latched values, zero for illegal opcodes.
module structural_alu
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic [2:0]  op_in,
    output logic [15:0] result,
    output logic        illegal
);

    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [2:0]  op_r;

    // Operand latches, captured when the sequencer accepts an instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= 16'h0000;
            b_r  <= 16'h0000;
            op_r <= 3'b000;
        end else if (load) begin
            a_r  <= a_in;
            b_r  <= b_in;
            op_r <= op_in;
        end else begin
            a_r  <= a_r;
            b_r  <= b_r;
            op_r <= op_r;
        end
    end

    // Datapath; arithmetic wraps modulo 2^16.
    always_comb begin
        result  = 16'h0000;
        illegal = is_illegal(op_r);
        case (op_r)
            OP_ADD:  result = a_r + b_r;
            OP_SUB:  result = a_r - b_r;
            OP_AND:  result = a_r & b_r;
            OP_OR:   result = a_r | b_r;
            OP_XOR:  result = a_r ^ b_r;
            OP_NOT:  result = ~a_r;
            default: result = 16'h0000;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue operand/writeback sequencer: IDLE accepts and latches
// operands, EXEC runs the ALU and writes back, RESP presents the result.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_opcode,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_result,
    output logic          out_zero,
    output logic          out_neg,
    output logic          out_illegal,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [15:0]   ld_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [15:0]   dbg_data
);

    seq_state_e    state_r;
    seq_state_e    next_state_s;
    logic [AW-1:0] rd_r;
    logic          accept_s;
    logic          wb_en_s;
    logic [15:0]   rs1_data_s;
    logic [15:0]   rs2_data_s;
    logic [15:0]   alu_result_s;
    logic          alu_illegal_s;
    logic [15:0]   resp_result_s;
    logic          out_valid_r;
    logic [15:0]   out_result_r;
    logic          out_zero_r;
    logic          out_neg_r;
    logic          out_illegal_r;

    assign accept_s      = in_valid && (state_r == IDLE);
    assign wb_en_s       = (state_r == EXEC) && !alu_illegal_s;
    assign resp_result_s = alu_illegal_s ? 16'h0000 : alu_result_s;

    assign in_ready    = (state_r == IDLE);
    assign out_valid   = out_valid_r;
    assign out_result  = out_result_r;
    assign out_zero    = out_zero_r;
    assign out_neg     = out_neg_r;
    assign out_illegal = out_illegal_r;

    alu_seq_regfile #(.NREGS(NREGS), .AW(AW)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (in_rs1),
        .rs1_data (rs1_data_s),
        .rs2_addr (in_rs2),
        .rs2_data (rs2_data_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wb_en    (wb_en_s),
        .wb_addr  (rd_r),
        .wb_data  (alu_result_s),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    structural_alu u_alu (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept_s),
        .a_in    (rs1_data_s),
        .b_in    (rs2_data_s),
        .op_in   (in_opcode),
        .result  (alu_result_s),
        .illegal (alu_illegal_s)
    );

    // FSM state and destination register latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            rd_r    <= '0;
        end else begin
            state_r <= next_state_s;
            rd_r    <= accept_s ? in_rd : rd_r;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    next_state_s = EXEC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EXEC: next_state_s = RESP;
            RESP: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Response registers: loaded at the end of EXEC, held until handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_result_r  <= 16'h0000;
            out_zero_r    <= 1'b0;
            out_neg_r     <= 1'b0;
            out_illegal_r <= 1'b0;
        end else if (state_r == EXEC) begin
            out_valid_r   <= 1'b1;
            out_result_r  <= resp_result_s;
            out_zero_r    <= (resp_result_s == 16'h0000);
            out_neg_r     <= resp_result_s[15];
            out_illegal_r <= alu_illegal_s;
        end else if ((state_r == RESP) && out_ready) begin
            out_valid_r   <= 1'b0;
        end else begin
            out_valid_r   <= out_valid_r;
        end
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Single-issue operand/writeback sequencer wrapped around the team ALU (`structural_alu`). It holds an 8-entry × 16-bit register file and accepts register-to-register instructions over a valid/ready handshake. For each instruction it reads operands and drives the ALU for one cycle. It then writes the result back and returns result plus zero/negative status over a second valid/ready handshake.

## Interface
Parameters:
- `NREGS`, 8: register-file depth; power of two.
- `AW`, 3: register address width, equal to log2(`NREGS`).

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: sequencer can accept an instruction.
- `in_opcode` in 3: ALU opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110/111 illegal).
- `in_rd`, `in_rs1`, `in_rs2` in `AW` each: destination and source register indices.
- `out_valid` out 1: response present.
- `out_ready` in 1: consumer takes the response.
- `out_result` out 16: ALU result.
- `out_zero` out 1: `out_result` == 0.
- `out_neg` out 1: `out_result[15]`.
- `out_illegal` out 1: opcode was 110 or 111.
- `ld_en` in 1: direct register load strobe (bench/boot path).
- `ld_addr` in `AW`: load target register.
- `ld_data` in 16: load data.
- `dbg_addr` in `AW`: debug read index.
- `dbg_data` out 16: combinational read of register `dbg_addr`.

## Operation
- FSM states are IDLE, EXEC and RESP. Reset state is IDLE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, latch `opA` = rf[rs1], `opB` = rf[rs2], `op` = opcode and `rd`, then go to EXEC.
- EXEC:
  - The ALU is driven from `opA`, `opB` and `op`; its combinational result is sampled at the end of the cycle.
  - For opcodes 000–101: write rf[rd] ← result, unless rd == 0.
  - For 110/111: no write; the response carries result 0 and `out_illegal` = 1.
  - Load `out_*` registers, then go to RESP.
- RESP:
  - `out_valid` = 1; `out_*` are held stable until `out_valid && out_ready`.
  - On that handshake, go to IDLE.
- r0 is hardwired to zero. Writes to r0, by writeback or load, are discarded, and reads of r0 always return 0.
- Arithmetic is 16-bit two's complement and wraps modulo 2^16. Carry and overflow are not reported.
- Register load path:
  - `ld_en` writes rf[`ld_addr`] ← `ld_data` at the clock edge, in any state.
  - If a load and an EXEC writeback target the same register on the same edge, the writeback wins.
  - A load to a source register after the instruction is accepted does not affect that instruction; operands are latched in IDLE.
- A new instruction can never be accepted while EXEC or RESP is active.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - State = IDLE, `out_valid` = 0, `out_result` = 0, `out_zero` = 0, `out_neg` = 0, `out_illegal` = 0.
  - All rf entries = 0, and `opA`/`opB`/`op`/`rd` = 0.
  - `in_ready` = 1 after reset.
- Latency:
  - Accept edge at cycle t. EXEC runs in cycle t+1. `out_valid` and the rf write are visible from cycle t+2.
  - With `out_ready` held at 1, `in_ready` returns to 1 in cycle t+3.
  - Maximum throughput is one instruction per 3 cycles.
- Back-to-back: an instruction reading the previous rd sees the written value, because the writeback happens before the next accept.
- `in_ready` depends only on state, not on `in_valid`. `out_valid` never depends on `out_ready`.
- Reset asserted mid-EXEC or mid-RESP:
  - The pending writeback is dropped and the response is lost.
  - All state returns to reset values immediately.

## Structure
- Package `alu_seq_pkg` holds:
  - The opcode constants: `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`, `OP_XOR`, `OP_NOT`.
  - The state enum (IDLE, EXEC, RESP).
  - `AW`/`NREGS` defaults and the `is_illegal(op)` function.
- Sub-modules:
  - One instance of `structural_alu`; its `clk`/`rst_n` are tied to the sequencer's.
  - Register file as sub-module `alu_seq_regfile`: 2 combinational read ports plus the debug port, and 1 prioritised write (writeback over load), with r0 forced to zero.

## Test plan
- Load r1 = 0x7FFF, r2 = 0x0001; ADD rd=3, rs1=1, rs2=2 → response 0x8000 with neg=1, zero=0; `dbg` r3 = 0x8000; `out_valid` first seen 2 cycles after accept.
- Load r4 = r5 = 0x1234; SUB rd=6 → 0x0000 with zero=1; then SUB r1 − r2 with r1 = 0, r2 = 1 → 0xFFFF, neg=1.
- NOT rd=0, rs1=1 with r1 = 0x00FF → response 0xFF00; `dbg` r0 stays 0x0000; `ld_en` to r0 with 0xBEEF also leaves 0.
- Opcode 110, rd=2 → response 0x0000 with `out_illegal` = 1; r2 unchanged.
- `out_ready` held 0 for 5 cycles in RESP → `out_*` stable and `in_ready` = 0 throughout; release → `in_ready` = 1 the next cycle.
- Reset pulse during EXEC of ADD r7 ← 3 + 4 → r7 = 0, `out_valid` = 0, `in_ready` = 1 after release; also same-edge load r7 = 0x1111 with writeback to r7 of 0x0007 → r7 = 0x0007.
